// File: rtl/rotame_pkg.sv
// Shared types and constants for the rotation frame-buffer write path.
package rotame_pkg;

  localparam int unsigned ADDR_W = 28;

  typedef enum logic [3:0] {
    ROT_90  = 4'd1,
    ROT_180 = 4'd2,
    ROT_270 = 4'd4,
    ROT_0   = 4'd8
  } rot_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    DRAIN
  } wr_state_e;

  // Anything other than a single valid one-hot code means "no rotation".
  function automatic rot_mode_e decode_mode(input logic [3:0] sel);
    case (sel)
      4'd1:    return ROT_90;
      4'd2:    return ROT_180;
      4'd4:    return ROT_270;
      default: return ROT_0;
    endcase
  endfunction

endpackage

// File: rtl/rotame_addr_fifo.sv
// Synchronous FIFO with a registered head copy; an entry leaves storage only on handshake.
module rotame_addr_fifo #(
  parameter int unsigned WIDTH = 44,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             push_ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, avail;
  logic             valid_q, pop, push_ok;
  logic [WIDTH-1:0] rdata_q;

  assign pop          = valid_q & ready_i;
  assign push_ready_o = (cnt_q != CNT_W'(DEPTH)) | pop;
  assign push_ok      = push_i & push_ready_o;
  // Entries already resident in storage after this cycle's pop; a same-cycle push is not yet readable.
  assign avail        = cnt_q - CNT_W'(pop);
  assign rd_ptr_d     = rd_ptr_q + PTR_W'(pop);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= (avail != '0);
      if (avail != '0) rdata_q <= mem_q[rd_ptr_d];
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rotame_wr_addr_gen.sv
// Maps each incoming source pixel to its rotated frame-buffer address using
// incremental accumulators, and queues address/pixel pairs for the DDR3 writer.
module rotame_wr_addr_gen
  import rotame_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 28'd0,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 16
) (
  input  logic              clk_wr,
  input  logic              rst_n,
  input  logic              wr_vsync,
  input  logic              wr_de,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        change_en,
  input  logic [10:0]       s_width,
  input  logic [10:0]       s_height,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_busy,
  output logic              overflow,
  output logic              frame_err
);

  wr_state_e         state_q, state_d;
  rot_mode_e         mode_q;
  logic              vs1_q, vs2_q, frame_start;
  logic              setup_cnt_q;
  logic [10:0]       w_q, h_q, x_q, y_q;
  logic [ADDR_W-1:0] p_q, addr_q, row_base_q, col_step_q, row_step_q;
  logic [ADDR_W-1:0] w_ext, h_ext, start_off, col_step, row_step;
  logic              overflow_q, frame_err_q;
  logic              px_take, err_set, load_geom, last_col, last_px;
  logic              push_ready, fifo_empty;

  assign frame_start = vs2_q & ~vs1_q;
  assign last_col    = (x_q == w_q - 11'd1);
  assign last_px     = last_col && (y_q == h_q - 11'd1);

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    px_take   = 1'b0;
    err_set   = 1'b0;
    load_geom = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = SETUP;
        else if (wr_de)  err_set = 1'b1;
      end
      SETUP: begin
        if (wr_de) err_set = 1'b1;
        if (setup_cnt_q) begin
          if (w_q == '0 || h_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = ACTIVE;
            load_geom = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (wr_de) begin
          px_take = 1'b1;
          if (last_px) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_de)      err_set = 1'b1;
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new frame start aborts whatever is in progress; the FIFO keeps its contents.
    if (frame_start) begin
      state_d   = SETUP;
      px_take   = 1'b0;
      err_set   = 1'b0;
      load_geom = 1'b0;
    end
  end

  always_comb begin
    w_ext     = {{(ADDR_W-11){1'b0}}, w_q};
    h_ext     = {{(ADDR_W-11){1'b0}}, h_q};
    start_off = '0;
    col_step  = ADDR_W'(1);
    row_step  = w_ext;
    case (mode_q)
      ROT_90: begin
        start_off = h_ext - ADDR_W'(1);
        col_step  = h_ext;
        row_step  = '1;
      end
      ROT_180: begin
        start_off = p_q - ADDR_W'(1);
        col_step  = '1;
        row_step  = '0 - w_ext;
      end
      ROT_270: begin
        start_off = p_q - h_ext;
        col_step  = '0 - h_ext;
        row_step  = ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      vs1_q       <= 1'b0;
      vs2_q       <= 1'b0;
      setup_cnt_q <= 1'b0;
      mode_q      <= ROT_0;
      w_q         <= '0;
      h_q         <= '0;
      p_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      row_base_q  <= '0;
      col_step_q  <= '0;
      row_step_q  <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vs1_q       <= wr_vsync;
      vs2_q       <= vs1_q;
      setup_cnt_q <= (state_q == SETUP) && !setup_cnt_q && !frame_start;
      if (frame_start) begin
        w_q    <= s_width;
        h_q    <= s_height;
        mode_q <= decode_mode(change_en);
      end
      if (state_q == SETUP && !setup_cnt_q)
        p_q <= {{(ADDR_W-11){1'b0}}, w_q} * {{(ADDR_W-11){1'b0}}, h_q};
      if (load_geom) begin
        x_q        <= '0;
        y_q        <= '0;
        addr_q     <= BASE_ADDR + start_off;
        row_base_q <= BASE_ADDR + start_off;
        col_step_q <= col_step;
        row_step_q <= row_step;
      end else if (px_take) begin
        // Geometry advances even for dropped pixels so later addresses stay aligned.
        if (last_col) begin
          x_q        <= '0;
          y_q        <= y_q + 11'd1;
          row_base_q <= row_base_q + row_step_q;
          addr_q     <= row_base_q + row_step_q;
        end else begin
          x_q    <= x_q + 11'd1;
          addr_q <= addr_q + col_step_q;
        end
      end
      if (frame_start) begin
        overflow_q  <= 1'b0;
        frame_err_q <= 1'b0;
      end else begin
        if (err_set)                overflow_q  <= overflow_q;
        if (err_set)                frame_err_q <= 1'b1;
        if (px_take && !push_ready) overflow_q  <= 1'b1;
      end
    end
  end

  rotame_addr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_wr),
    .rst_ni       (rst_n),
    .push_i       (px_take),
    .wdata_i      ({addr_q, wr_data}),
    .push_ready_o (push_ready),
    .valid_o      (out_valid),
    .ready_i      (out_ready),
    .rdata_o      ({out_addr, out_data}),
    .empty_o      (fifo_empty)
  );

  assign frame_busy = (state_q != IDLE) | ~fifo_empty;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_rotame_wr_addr_gen.sv
// Randomized bench for rotame_wr_addr_gen, scored against a closed-form rotation model.
module tb_rotame_wr_addr_gen;
  import rotame_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [27:0] BASE  = 28'h100;

  logic          clk_wr = 1'b0;
  logic          rst_n;
  logic          wr_vsync, wr_de, out_ready;
  logic [DW-1:0] wr_data;
  logic [3:0]    change_en;
  logic [10:0]   s_width, s_height;
  logic          out_valid, frame_busy, overflow, frame_err;
  logic [27:0]   out_addr;
  logic [DW-1:0] out_data;

  always #5 clk_wr = ~clk_wr;

  rotame_wr_addr_gen #(
    .BASE_ADDR  (BASE),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_wr     (clk_wr),
    .rst_n      (rst_n),
    .wr_vsync   (wr_vsync),
    .wr_de      (wr_de),
    .wr_data    (wr_data),
    .change_en  (change_en),
    .s_width    (s_width),
    .s_height   (s_height),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .frame_busy (frame_busy),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned n_pop    = 0;

  logic [43:0] sb [$];
  int unsigned m_w, m_h, m_rem;
  int          m_mode;
  bit          m_ovf, m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Destination of source pixel (x,y) after rotation, as an offset into a W*H frame.
  function automatic logic [27:0] ref_addr(input int mode, input int unsigned w, h, x, y);
    int unsigned off;
    case (mode)
      1:       off = x * h + (h - 1 - y);
      2:       off = w * h - 1 - (y * w + x);
      4:       off = (w - 1 - x) * h + y;
      default: off = y * w + x;
    endcase
    return BASE + 28'(off);
  endfunction

  task automatic cycle(input bit de, input bit rdy);
    logic [DW-1:0] d;
    logic [44:0]   exp_head;
    bit            pop, acc;
    int unsigned   idx;
    d         = DW'($urandom);
    wr_de     = de;
    wr_data   = d;
    out_ready = rdy;
    if (out_valid) begin
      exp_head = (sb.size() != 0) ? {1'b0, sb[0]} : {1'b1, 44'd0};
      check("head", {1'b0, out_addr, out_data}, exp_head);
    end
    pop = out_valid && rdy;
    acc = (sb.size() < DEPTH) || pop;
    if (pop) begin
      n_pop++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    if (de) begin
      if (m_rem == 0) m_err = 1'b1;
      else begin
        idx = m_w * m_h - m_rem;
        m_rem--;
        if (acc) sb.push_back({ref_addr(m_mode, m_w, m_h, idx % m_w, idx / m_w), d});
        else     m_ovf = 1'b1;
      end
    end
    @(posedge clk_wr);
    @(negedge clk_wr);
    wr_de = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] ce, input int unsigned w, h, input bit rdy);
    change_en = ce;
    s_width   = 11'(w);
    s_height  = 11'(h);
    wr_vsync  = 1'b1;
    cycle(0, rdy);
    cycle(0, rdy);
    wr_vsync  = 1'b0;
    m_mode = (ce == 4'd1 || ce == 4'd2 || ce == 4'd4) ? int'(ce) : 8;
    m_w    = w;
    m_h    = h;
    m_rem  = w * h;
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    repeat (5) cycle(0, rdy);
    if (w * h > 0) check("busy_hi", frame_busy, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      cycle(0, 1);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    n = 0;
    while (frame_busy && n < 8) begin
      cycle(0, 1);
      n++;
    end
    check("busy_fall", frame_busy, 0);
    check("overflow", overflow, m_ovf);
    check("frame_err", frame_err, m_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned p0, w, h;
    logic [3:0]  ce;
    rst_n = 1'b0; wr_vsync = 1'b0; wr_de = 1'b0; wr_data = '0; out_ready = 1'b0;
    change_en = 4'd8; s_width = '0; s_height = '0;
    m_rem = 0; m_w = 1; m_h = 1; m_mode = 8; m_ovf = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge clk_wr);
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", frame_err, 0);
    rst_n = 1'b1;
    @(negedge clk_wr);

    // Each rotation on a 4x2 frame: latency, throughput and ordering.
    for (int i = 0; i < 4; i++) begin
      ce = (i == 0) ? 4'd8 : 4'(1 << (i - 1));
      start_frame(ce, 4, 2, 1);
      p0 = n_pop;
      cycle(1, 1);
      check("lat_n1", out_valid, 0);
      cycle(1, 1);
      check("lat_n2", out_valid, 1);
      repeat (6) cycle(1, 1);
      repeat (2) cycle(0, 1);
      check("throughput", n_pop - p0, 8);
      drain();
    end

    // Back-pressure: six pixels into a four-entry FIFO.
    start_frame(4'd8, 4, 2, 0);
    repeat (6) cycle(1, 0);
    check("ovf_set", overflow, m_ovf);
    check("ovf_held", sb.size(), DEPTH);
    p0 = n_pop;
    repeat (7) cycle(0, 1);
    check("ovf_drained", n_pop - p0, 4);
    repeat (2) cycle(1, 1);
    drain();

    // Invalid select code falls back to no rotation.
    start_frame(4'b0011, 3, 2, 1);
    repeat (6) cycle(1, 1);
    drain();

    // Mid-frame restart with a new mode.
    start_frame(4'd1, 4, 2, 1);
    repeat (3) cycle(1, 1);
    start_frame(4'd2, 4, 2, 1);
    repeat (8) cycle(1, 1);
    cycle(1, 1);
    drain();

    // Zero width: every pixel is an error.
    start_frame(4'd8, 0, 3, 1);
    repeat (2) cycle(1, 1);
    drain();

    // Random frames with random pacing and back-pressure.
    for (int f = 0; f < 14; f++) begin
      case ($urandom % 5)
        0:       ce = 4'd1;
        1:       ce = 4'd2;
        2:       ce = 4'd4;
        3:       ce = 4'd8;
        default: ce = 4'($urandom);
      endcase
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 5);
      start_frame(ce, w, h, 1);
      for (int n = 0; n < 400 && m_rem > 0; n++)
        cycle(($urandom % 5) != 0, ($urandom % 4) != 0);
      if (($urandom % 3) == 0) cycle(1, 1);
      drain();
    end

    // Asynchronous reset in the middle of a frame.
    start_frame(4'd4, 5, 3, 0);
    repeat (3) cycle(1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_addr", out_addr, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", frame_busy, 0);
    check("arst_ovf", overflow, 0);
    check("arst_err", frame_err, 0);
    sb.delete();
    m_rem = 0; m_ovf = 1'b0; m_err = 1'b0;
    @(negedge clk_wr);
    @(negedge clk_wr);
    rst_n = 1'b1;
    @(negedge clk_wr);
    start_frame(4'd2, 3, 3, 1);
    repeat (9) cycle(1, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotame_wr_addr_gen.md
# rotame_wr_addr_gen

Write-side address generator for the rotation frame buffer, in the `clk_wr` domain between the camera pixel stream and the DDR3 write port. It latches the rotation mode and source resolution at each frame start. It then maps every incoming source pixel to its rotated destination address, so the read side can fetch the rotated image linearly with swapped width and height. Address/data pairs are buffered in a small FIFO and drained to the DDR3 write arbiter through a valid/ready handshake.

## Interface
Parameters:
- `BASE_ADDR`, 28'd0: frame-buffer base word address.
- `DATA_W`, 16: pixel width.
- `FIFO_DEPTH`, 16: output FIFO entries (power of two, ≥4).

Ports:
- `clk_wr`, input, 1: write clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `wr_vsync`, input, 1: frame sync, active-high; frame starts on its falling edge.
- `wr_de`, input, 1: pixel valid.
- `wr_data`, input, DATA_W: pixel.
- `change_en`, input, 4: rotation select (1 = 90°, 2 = 180°, 4 = 270°, 8 = none); already synchronous to `clk_wr`.
- `s_width`, input, 11: source width W.
- `s_height`, input, 11: source height H.
- `out_valid`, output, 1: FIFO head valid.
- `out_ready`, input, 1: consumer accepts head.
- `out_addr`, output, 28: destination word address.
- `out_data`, output, DATA_W: pixel.
- `frame_busy`, output, 1: frame in progress or FIFO non-empty.
- `overflow`, output, 1: sticky; a pixel was dropped because the FIFO was full.
- `frame_err`, output, 1: sticky; excess pixels (more than H lines) arrived.

## Operation
- Reset values: all outputs 0, state IDLE, mode = 8, FIFO empty.
- Frame start = `wr_vsync` registered for one cycle, then detected as a falling edge.
- At frame start, latch W, H and mode, and clear `overflow` and `frame_err`.
- Mode decoding: any `change_en` value that is not exactly 1, 2, 4 or 8 is treated as 8.
- FSM states:
  - IDLE: on frame start, go to SETUP.
  - SETUP: 2 cycles. Compute P = W*H (one registered multiply) and the start address, column step and row step. Then go to ACTIVE.
  - ACTIVE: on each `wr_de`, push {addr, data}, advance x, and on x = W−1 wrap x and advance y and the row base. After the pixel with y = H−1, x = W−1, go to DRAIN.
  - DRAIN: when the FIFO is empty, go to IDLE.
- A frame start seen in ACTIVE or DRAIN aborts the current frame and goes to SETUP. The FIFO is not flushed.
- `wr_de` in IDLE or SETUP: pixel is dropped and `frame_err` is set.
- Incremental addressing, no per-pixel multiply. Destination address = BASE_ADDR + row_base + x·col_step, implemented by accumulators:
  - mode 8: start 0, col +1, row +W
  - mode 1: start H−1, col +H, row −1
  - mode 2: start P−1, col −1, row −W
  - mode 4: start P−H, col −H, row +1
- Arithmetic is 28-bit two's complement, wrapping modulo 2^28.
- FIFO full on a `wr_de`: the pixel is dropped, `overflow` is set, and x/y still advance so geometry stays aligned.
- A FIFO push and pop in the same cycle are both allowed when full. The push then succeeds.
- `out_addr`/`out_data` hold stable while `out_valid` is high and `out_ready` is low.
- W = 0 or H = 0: SETUP goes directly to IDLE, and every pixel sets `frame_err`.

## Timing
- Latency from `wr_de` at cycle N (FIFO empty) to `out_valid` is 2 cycles: high at cycle N+2.
- Sustained throughput is 1 pixel per cycle when `out_ready` is held high.
- Frame start edge to ACTIVE is 4 cycles: 1 cycle sync, 1 cycle detect, 2 cycles SETUP. Pixels must not arrive earlier.
- `frame_busy` rises the cycle after the frame start is detected. It falls the cycle after DRAIN exits.

## Structure
- Shared package `rotame_pkg`:
  - rotation mode encodings ROT_0 = 8, ROT_90 = 1, ROT_180 = 2, ROT_270 = 4
  - FSM state typedef
  - address width constant 28
- Sub-module `rotame_addr_fifo`: synchronous FIFO, FIFO_DEPTH × (28 + DATA_W), registered output.

## Test plan
- Mode 8, W = 4, H = 2, `out_ready` = 1 → addresses 0, 1, …, 7 in order; `frame_busy` falls after the 8th pop.
- Mode 1, W = 4, H = 2 → addresses 1, 3, 5, 7, 0, 2, 4, 6.
- Mode 2, W = 4, H = 2 → addresses 7, 6, …, 0. Mode 4, W = 4, H = 2 → addresses 6, 4, 2, 0, 7, 5, 3, 1.
- FIFO_DEPTH = 4, `out_ready` = 0, 6 pixels → 4 entries held, `overflow` = 1; releasing `out_ready` drains exactly 4 entries with correct addresses.
- `change_en` = 4'b0011 → behaves as mode 8. A new vsync mid-frame → next address restarts at that mode's start; BASE_ADDR = 0x100 offsets all addresses.
- `rst_n` asserted mid-frame → all outputs 0 immediately. The next frame after release is generated correctly.
